// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch cell-update datapath:
// traceback codes, scoring defaults, the controller state type and the saturating adder.
package nw_pkg;

    localparam logic [1:0] DIR_DIAG = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_LEFT = 2'd2;

    localparam int NW_MATCH    = 1;
    localparam int NW_MISMATCH = -1;
    localparam int NW_GAP      = -2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_RD2,
        ST_WAIT,
        ST_CALC,
        ST_WR
    } nw_state_e;

    // Add in full int precision (never overflows for w <= 30), then clamp to a w-bit signed range.
    function automatic int sat_add(input int a, input int b, input int w);
        int s;
        int hi;
        int lo;
        s  = a + b;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/nw_max3_sel.sv
// Three-way saturating max for one score cell: diag+sub, up+gap, left+gap.
// Ties resolve diag over up over left; dir_o reports the winning neighbour.
module nw_max3_sel
    import nw_pkg::*;
#(
    parameter int W = 16
) (
    input  logic signed [W-1:0] diag_i,
    input  logic signed [W-1:0] up_i,
    input  logic signed [W-1:0] left_i,
    input  logic signed [W-1:0] sub_i,
    input  logic signed [W-1:0] gap_i,
    output logic signed [W-1:0] score_o,
    output logic [1:0]          dir_o
);

    int cand_diag;
    int cand_up;
    int cand_left;
    int cand_best;

    always_comb begin
        cand_diag = sat_add(int'(diag_i), int'(sub_i), W);
        cand_up   = sat_add(int'(up_i),   int'(gap_i), W);
        cand_left = sat_add(int'(left_i), int'(gap_i), W);
        cand_best = cand_diag;
        dir_o     = DIR_DIAG;
        if ((cand_diag >= cand_up) && (cand_diag >= cand_left)) begin
            cand_best = cand_diag;
            dir_o     = DIR_DIAG;
        end else if (cand_up >= cand_left) begin
            cand_best = cand_up;
            dir_o     = DIR_UP;
        end else begin
            cand_best = cand_left;
            dir_o     = DIR_LEFT;
        end
        score_o = W'(cand_best);
    end

endmodule

// File: rtl/score_cell_update.sv
// Per-cell compute stage: reads diag/up/left via the address generator, writes cell (i+1,j+1).
// Define TRACEBACK_DIR_EN to expose the traceback pointer on port dir.
//
// state | meaning
// IDLE  | waiting for start; bad indices raise err
// RD0   | present count=0 (diag)
// RD1   | present count=1 (up)
// RD2   | present count=2 (left)
// WAIT  | down-count while the last reads drain through the RAM pipe
// CALC  | compute max, register waddr/wdata/dir
// WR    | we/done high for one cycle
module score_cell_update
    import nw_pkg::*;
#(
    parameter int N        = 128,
    parameter int W        = 16,
    parameter int RD_LAT   = 2,
    parameter int MATCH    = NW_MATCH,
    parameter int MISMATCH = NW_MISMATCH,
    parameter int GAP      = NW_GAP,
    localparam int BitAddr     = $clog2(N + 1),
    localparam int IW          = BitAddr + 1,
    localparam int addr_lenght = $clog2((N + 1) * (N + 1) - 1),
    localparam int AW          = addr_lenght + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IW-1:0]       i,
    input  logic [IW-1:0]       j,
    input  logic [1:0]          char_a,
    input  logic [1:0]          char_b,
    output logic                en_read,
    output logic [1:0]          count,
    output logic                change_index,
    input  logic signed [W-1:0] rdata,
    output logic                we,
    output logic [AW-1:0]       waddr,
    output logic signed [W-1:0] wdata,
`ifdef TRACEBACK_DIR_EN
    output logic [1:0]          dir,
`endif
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int WCW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    nw_state_e state_q, state_d;
    logic [WCW-1:0] wait_q, wait_d;

    logic                en_read_q;
    logic [1:0]          count_q;
    logic                change_index_q;
    logic                we_q;
    logic [AW-1:0]       waddr_q;
    logic signed [W-1:0] wdata_q;
    logic                err_q;

    logic [IW-1:0]       i_q, j_q;
    logic [1:0]          ca_q, cb_q;
    logic signed [W-1:0] diag_q, up_q, left_q;

    logic [RD_LAT-1:0]   tag_vld_q;
    logic [1:0]          tag_cnt_q [RD_LAT];

    logic                bad_idx;
    logic                reading_d;
    logic signed [W-1:0] sub_s;
    logic signed [W-1:0] gap_s;
    logic signed [W-1:0] sel_score;
    logic [AW-1:0]       row_a, col_a, waddr_calc;

    assign bad_idx = (int'(i) >= N) || (int'(j) >= N);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !bad_idx) begin
                    state_d = ST_RD0;
                end
            end
            ST_RD0: state_d = ST_RD1;
            ST_RD1: state_d = ST_RD2;
            ST_RD2: begin
                state_d = ST_WAIT;
                wait_d  = WCW'(RD_LAT);
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_CALC;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_CALC: state_d = ST_WR;
            ST_WR:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign reading_d = (state_d == ST_RD0) || (state_d == ST_RD1) || (state_d == ST_RD2);

    assign sub_s = (ca_q == cb_q) ? W'(MATCH) : W'(MISMATCH);
    assign gap_s = W'(GAP);

    // Index arithmetic is done at address width so (N+1)*(i+1) cannot truncate.
    assign row_a      = AW'(i_q) + AW'(1);
    assign col_a      = AW'(j_q) + AW'(1);
    assign waddr_calc = col_a + AW'(N + 1) * row_a;

`ifdef TRACEBACK_DIR_EN
    logic [1:0] sel_dir;
    logic [1:0] dir_q;
`else
    logic [1:0] sel_dir_unused;
`endif

    nw_max3_sel #(.W(W)) u_max3 (
        .diag_i  (diag_q),
        .up_i    (up_q),
        .left_i  (left_q),
        .sub_i   (sub_s),
        .gap_i   (gap_s),
        .score_o (sel_score),
`ifdef TRACEBACK_DIR_EN
        .dir_o   (sel_dir)
`else
        .dir_o   (sel_dir_unused)
`endif
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            wait_q         <= '0;
            en_read_q      <= 1'b0;
            count_q        <= 2'd0;
            change_index_q <= 1'b1;
            we_q           <= 1'b0;
            waddr_q        <= '0;
            wdata_q        <= '0;
            err_q          <= 1'b0;
            i_q            <= '0;
            j_q            <= '0;
            ca_q           <= '0;
            cb_q           <= '0;
            diag_q         <= '0;
            up_q           <= '0;
            left_q         <= '0;
`ifdef TRACEBACK_DIR_EN
            dir_q          <= DIR_DIAG;
`endif
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            en_read_q      <= reading_d;
            change_index_q <= !reading_d;
            we_q           <= (state_d == ST_WR);
            err_q          <= (state_q == ST_IDLE) && start && bad_idx;
            case (state_d)
                ST_RD0:  count_q <= 2'd0;
                ST_RD1:  count_q <= 2'd1;
                ST_RD2:  count_q <= 2'd2;
                default: count_q <= count_q;
            endcase
            if ((state_q == ST_IDLE) && start && !bad_idx) begin
                i_q  <= i;
                j_q  <= j;
                ca_q <= char_a;
                cb_q <= char_b;
            end
            if (tag_vld_q[RD_LAT-1]) begin
                case (tag_cnt_q[RD_LAT-1])
                    2'd0:    diag_q <= rdata;
                    2'd1:    up_q   <= rdata;
                    2'd2:    left_q <= rdata;
                    default: ;
                endcase
            end
            if (state_q == ST_CALC) begin
                waddr_q <= waddr_calc;
                wdata_q <= sel_score;
`ifdef TRACEBACK_DIR_EN
                dir_q   <= sel_dir;
`endif
            end
        end
    end

    // Tag pipe mirrors the generator's address register plus the RAM read stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                tag_cnt_q[k] <= 2'd0;
            end
        end else begin
            tag_vld_q[0] <= en_read_q;
            tag_cnt_q[0] <= count_q;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_cnt_q[k] <= tag_cnt_q[k-1];
            end
        end
    end

    assign en_read      = en_read_q;
    assign count        = count_q;
    assign change_index = change_index_q;
    assign we           = we_q;
    assign done         = we_q;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign err          = err_q;
    assign busy         = (state_q != ST_IDLE);
`ifdef TRACEBACK_DIR_EN
    assign dir          = dir_q;
`endif

endmodule

// File: tb/tb_score_cell_update.sv
// Bench for score_cell_update at N=4, W=8, RD_LAT=2 with an address-generator + sync RAM model.
module tb_score_cell_update;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = $clog2(N + 1) + 1;
    localparam int AW = $clog2((N + 1) * (N + 1) - 1) + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [IW-1:0]       i_s = '0;
    logic [IW-1:0]       j_s = '0;
    logic [1:0]          ca_s = '0;
    logic [1:0]          cb_s = '0;
    logic                en_read;
    logic [1:0]          count;
    logic                change_index;
    logic signed [W-1:0] rdata = '0;
    logic                we;
    logic [AW-1:0]       waddr;
    logic signed [W-1:0] wdata;
    logic [1:0]          dir;
    logic                busy;
    logic                done;
    logic                err;

    int n_pass  = 0;
    int n_total = 0;

    logic signed [W-1:0] mem [0:(N+1)*(N+1)-1];
    int gen_addr = 0;
    int rd_log[$];

    score_cell_update #(.N(N), .W(W), .RD_LAT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .i            (i_s),
        .j            (j_s),
        .char_a       (ca_s),
        .char_b       (cb_s),
        .en_read      (en_read),
        .count        (count),
        .change_index (change_index),
        .rdata        (rdata),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
`ifdef TRACEBACK_DIR_EN
        .dir          (dir),
`endif
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

`ifndef TRACEBACK_DIR_EN
    assign dir = 2'd0;
`endif

    always #5 clk = ~clk;

    function automatic int addr_of(input int c);
        if (c == 0) return int'(j_s) + (N + 1) * int'(i_s);
        if (c == 1) return int'(j_s) + 1 + (N + 1) * int'(i_s);
        return int'(j_s) + (N + 1) * (int'(i_s) + 1);
    endfunction

    // Address generator register followed by a registered RAM read: two cycles from count to rdata.
    always @(posedge clk) begin
        if (en_read) begin
            gen_addr <= addr_of(int'(count));
            rd_log.push_back(addr_of(int'(count)));
        end
        if (gen_addr >= 0 && gen_addr < (N + 1) * (N + 1)) rdata <= mem[gen_addr];
    end

    function automatic int clamp(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Reference: best of the three scored neighbours, earliest of {diag, up, left} wins a tie.
    task automatic ref_cell(input int d, input int u, input int l, input bit eq,
                            output int score, output int dsel);
        int c[3];
        c[0] = clamp(d + (eq ? 1 : -1));
        c[1] = clamp(u - 2);
        c[2] = clamp(l - 2);
        dsel = 0;
        for (int k = 1; k < 3; k++) if (c[k] > c[dsel]) dsel = k;
        score = c[dsel];
    endtask

    task automatic run_cell(input int ii, input int jj, input logic [1:0] ca, input logic [1:0] cb,
                            input int dup_at, input string nm);
        int exp_s, exp_d, lat, exp_a[3];
        bit seen;
        exp_a[0] = jj + (N + 1) * ii;
        exp_a[1] = jj + 1 + (N + 1) * ii;
        exp_a[2] = jj + (N + 1) * (ii + 1);
        ref_cell(int'(mem[exp_a[0]]), int'(mem[exp_a[1]]), int'(mem[exp_a[2]]), ca == cb, exp_s, exp_d);
        rd_log.delete();
        i_s = IW'(ii); j_s = IW'(jj); ca_s = ca; cb_s = cb;
        start = 1'b1;
        seen = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            start = (k == dup_at);
            if (k == 1) begin
                n_total++;
                if ({busy, en_read, count} !== 4'b1100)
                    $display("FAIL %s first_read busy/en_read/count got %b want 1100", nm, {busy, en_read, count});
                else n_pass++;
            end
            if (we === 1'b1) begin seen = 1'b1; lat = k - 1; end
        end
        start = 1'b0;
        n_total++;
        if (!seen) $display("FAIL %s we_timeout got no we want we within 20 cycles", nm);
        else n_pass++;
        n_total++;
        if (lat !== 7) $display("FAIL %s latency got %0d want 7", nm, lat);
        else n_pass++;
        n_total++;
        if (done !== 1'b1 || err !== 1'b0) $display("FAIL %s done/err got %b%b want 10", nm, done, err);
        else n_pass++;
        n_total++;
        if (waddr !== AW'((N + 1) * (ii + 1) + jj + 1))
            $display("FAIL %s waddr got %0d want %0d", nm, waddr, (N + 1) * (ii + 1) + jj + 1);
        else n_pass++;
        n_total++;
        if (wdata !== W'(exp_s)) $display("FAIL %s wdata got %0d want %0d", nm, wdata, exp_s);
        else n_pass++;
`ifdef TRACEBACK_DIR_EN
        n_total++;
        if (dir !== 2'(exp_d)) $display("FAIL %s dir got %0d want %0d", nm, dir, exp_d);
        else n_pass++;
`endif
        n_total++;
        if (rd_log.size() != 3 || rd_log[0] != exp_a[0] || rd_log[1] != exp_a[1] || rd_log[2] != exp_a[2])
            $display("FAIL %s read_order got %p want %0d,%0d,%0d", nm, rd_log, exp_a[0], exp_a[1], exp_a[2]);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (we !== 1'b0 || busy !== 1'b0) $display("FAIL %s we_width we/busy got %b%b want 00", nm, we, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++;
        if ({en_read, count, change_index, we, waddr, wdata, busy, done, err} !== {4'b0001, 1'b0, {AW{1'b0}}, {W{1'b0}}, 3'b000})
            $display("FAIL reset_values got %b want en_read=0 count=0 change_index=1 rest 0",
                     {en_read, count, change_index, we, waddr, wdata, busy, done, err});
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        mem[7] = 8'sd3;    mem[8] = 8'sd1;    mem[12] = 8'sd0;
        run_cell(1, 2, 2'd1, 2'd1, 0, "dir_match");
        mem[7] = -8'sd1;   mem[8] = 8'sd0;    mem[12] = -8'sd5;
        run_cell(1, 2, 2'd0, 2'd3, 0, "dir_tie");
        mem[7] = -8'sd128; mem[8] = -8'sd127; mem[12] = -8'sd128;
        run_cell(1, 2, 2'd2, 2'd1, 0, "dir_sat");
        mem[7] = 8'sd0;    mem[8] = 8'sd5;    mem[12] = 8'sd5;
        run_cell(1, 2, 2'd0, 2'd2, 0, "dir_up");
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            for (int a = 0; a < (N + 1) * (N + 1); a++) begin
                case ($urandom_range(0, 3))
                    0:       mem[a] = -8'sd128;
                    1:       mem[a] = 8'sd127;
                    default: mem[a] = 8'($urandom_range(0, 255));
                endcase
            end
            run_cell(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 0, "random");
        end
    endtask

    task automatic test_bad_index();
        bit saw_read;
        for (int t = 0; t < 2; t++) begin
            rd_log.delete();
            i_s = (t == 0) ? IW'(N) : IW'(0);
            j_s = (t == 0) ? IW'(0) : IW'(N + 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n_total++;
            if (err !== 1'b1) $display("FAIL bad_index_err got %b want 1", err);
            else n_pass++;
            saw_read = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (en_read !== 1'b0 || busy !== 1'b0 || err !== 1'b0) saw_read = 1'b1;
            end
            n_total++;
            if (saw_read || rd_log.size() != 0)
                $display("FAIL bad_index_idle got activity=%b reads=%0d want 0 0", saw_read, rd_log.size());
            else n_pass++;
        end
    endtask

    task automatic test_busy_start();
        int extra_we;
        mem[6] = 8'sd10; mem[7] = 8'sd2; mem[11] = -8'sd3;
        run_cell(1, 1, 2'd3, 2'd3, 3, "busy_start");
        extra_we = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (we === 1'b1 || busy === 1'b1 || err === 1'b1) extra_we++;
        end
        n_total++;
        if (extra_we != 0) $display("FAIL busy_start_ignored got %0d active cycles want 0", extra_we);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        mem[0] = 8'sd4; mem[1] = -8'sd4; mem[5] = 8'sd7;
        run_cell(0, 0, 2'd1, 2'd2, 0, "b2b_first");
        mem[18] = 8'sd9; mem[19] = 8'sd12; mem[23] = 8'sd12;
        run_cell(3, 3, 2'd1, 2'd1, 0, "b2b_second");
    endtask

    task automatic test_reset_mid();
        int we_seen;
        mem[7] = 8'sd20; mem[8] = 8'sd1; mem[12] = 8'sd1;
        i_s = IW'(1); j_s = IW'(2); ca_s = 2'd0; cb_s = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if ({en_read, count, change_index, we, waddr, wdata, busy, done, err} !== {4'b0001, 1'b0, {AW{1'b0}}, {W{1'b0}}, 3'b000})
            $display("FAIL reset_mid_values got %b want en_read=0 count=0 change_index=1 rest 0",
                     {en_read, count, change_index, we, waddr, wdata, busy, done, err});
        else n_pass++;
        we_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (we !== 1'b0) we_seen++;
        end
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (we !== 1'b0 || busy !== 1'b0) we_seen++;
        end
        n_total++;
        if (we_seen != 0) $display("FAIL reset_mid_no_write got %0d active cycles want 0", we_seen);
        else n_pass++;
        mem[7] = 8'sd3; mem[8] = 8'sd1; mem[12] = 8'sd0;
        run_cell(1, 2, 2'd1, 2'd1, 0, "after_reset");
    endtask

    initial begin
        for (int a = 0; a < (N + 1) * (N + 1); a++) mem[a] = '0;
        test_reset();
        test_directed();
        test_random();
        test_bad_index();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
